chn_wr_tlp_tx: RTL

//  Requester side of the channel/endpoint arbitration handshake (reqep/trn/drvn).

---
 rtl/chn_wr_tlp_tx_if.sv | 32 +++
 rtl/chn_wr_tlp_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/chn_wr_tlp_tx_if.sv
// Host-write job port, channel arbitration handshake and TRN TX bus
// for one channel's MWr32 requester.
interface chn_wr_tlp_tx_if;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] cfg_completer_id;
    logic        chn_reqep;
    logic        chn_trn;
    logic        chn_drvn;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    modport master (
        input  wr_addr, wr_data, wr_valid, cfg_completer_id,
        input  chn_trn, trn_tdst_rdy_n,
        output wr_ready, chn_reqep, chn_drvn,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );

    modport slave (
        output wr_addr, wr_data, wr_valid, cfg_completer_id,
        output chn_trn, trn_tdst_rdy_n,
        input  wr_ready, chn_reqep, chn_drvn,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );
endinterface

// File: rtl/chn_wr_tlp_tx.sv
// Per-channel MWr32 requester: queues host writes, requests the TX
// endpoint and sends up to MAX_BURST 1-DW TLPs per grant.
module chn_wr_tlp_tx #(
    parameter int FIFO_AW   = 2,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic rst,
    chn_wr_tlp_tx_if.master bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, REQ, H0, H1, REL} state_t;

    state_t state, state_nx;

    logic [31:0]      mem_a [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0] cnt;
    logic             full, empty, push, pop, acc;
    logic [BW-1:0]    burst, burst_nx;
    logic             low_seen, low_seen_nx;

    logic        reqep_q, drvn_q, sof_q, eof_q, src_q;
    logic [63:0] td_q, td_nx;
    logic [7:0]  trem_q, trem_nx;
    logic        reqep_nx, drvn_nx, sof_nx, eof_nx, src_nx;
    logic [31:0] hd_a, hd_d;

    assign full  = cnt == (FIFO_AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign acc   = !bus.trn_tdst_rdy_n;
    assign push  = bus.wr_valid && bus.wr_ready;
    assign hd_a  = mem_a[rp];
    assign hd_d  = mem_d[rp];

    assign bus.wr_ready       = !full && !rst;
    assign bus.chn_reqep      = reqep_q;
    assign bus.chn_drvn       = drvn_q;
    assign bus.trn_td         = td_q;
    assign bus.trn_trem_n     = trem_q;
    assign bus.trn_tsof_n     = sof_q;
    assign bus.trn_teof_n     = eof_q;
    assign bus.trn_tsrc_rdy_n = src_q;

    always_comb begin
        state_nx    = state;
        burst_nx    = burst;
        pop         = 1'b0;
        low_seen_nx = low_seen;
        unique case (state)
            IDLE: if (!empty && low_seen) state_nx = REQ;
            REQ: begin
                if (bus.chn_trn && low_seen) begin
                    state_nx    = H0;
                    low_seen_nx = 1'b0;
                end
            end
            H0: if (acc) state_nx = H1;
            H1: begin
                if (acc) begin
                    pop      = 1'b1;
                    burst_nx = burst + 1'b1;
                    if (cnt > (FIFO_AW+1)'(1) && burst_nx < BW'(MAX_BURST))
                        state_nx = H0;
                    else
                        state_nx = REL;
                end
            end
            REL: begin
                state_nx = IDLE;
                burst_nx = '0;
            end
            default: state_nx = IDLE;
        endcase
        if (!bus.chn_trn) low_seen_nx = 1'b1;
    end

    // Outputs are registered copies of what the next state presents
    always_comb begin
        reqep_nx = 1'b0;
        drvn_nx  = 1'b0;
        sof_nx   = 1'b1;
        eof_nx   = 1'b1;
        src_nx   = 1'b1;
        trem_nx  = 8'hFF;
        td_nx    = '0;
        unique case (state_nx)
            REQ: reqep_nx = 1'b1;
            H0: begin
                reqep_nx = 1'b1;
                drvn_nx  = 1'b1;
                sof_nx   = 1'b0;
                src_nx   = 1'b0;
                trem_nx  = 8'h00;
                td_nx    = {1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'h0,
                            1'b0, 1'b0, 2'b00, 2'b00, 10'd1,
                            bus.cfg_completer_id, 8'h00, 4'h0, 4'hF};
            end
            H1: begin
                reqep_nx = 1'b1;
                drvn_nx  = 1'b1;
                eof_nx   = 1'b0;
                src_nx   = 1'b0;
                trem_nx  = 8'h00;
                td_nx    = {hd_a[31:2], 2'b00,
                            hd_d[7:0], hd_d[15:8], hd_d[23:16], hd_d[31:24]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            burst    <= '0;
            low_seen <= 1'b1;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            reqep_q  <= 1'b0;
            drvn_q   <= 1'b0;
            sof_q    <= 1'b1;
            eof_q    <= 1'b1;
            src_q    <= 1'b1;
            trem_q   <= 8'hFF;
            td_q     <= '0;
        end else begin
            state    <= state_nx;
            burst    <= burst_nx;
            low_seen <= low_seen_nx;
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
            reqep_q <= reqep_nx;
            drvn_q  <= drvn_nx;
            sof_q   <= sof_nx;
            eof_q   <= eof_nx;
            src_q   <= src_nx;
            trem_q  <= trem_nx;
            td_q    <= td_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wp] <= bus.wr_addr;
            mem_d[wp] <= bus.wr_data;
        end
    end
endmodule
